// File: rtl/drift_mon_pkg.sv
// Shared types and constants for the drift accuracy monitor.
package drift_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAM  = 2'd1,
        S_RAM2 = 2'd2,
        S_ACK  = 2'd3
    } slave_state_t;

    localparam logic [3:0] REG_CTRL          = 4'd0;
    localparam logic [3:0] REG_STATUS        = 4'd1;
    localparam logic [3:0] REG_TOTAL_SEEN    = 4'd2;
    localparam logic [3:0] REG_TOTAL_CORRECT = 4'd3;
    localparam logic [3:0] REG_WINDOW_IDX    = 4'd4;
    localparam logic [3:0] REG_THRESHOLD     = 4'd5;
    localparam logic [3:0] REG_HIST_ADDR     = 4'd6;
    localparam logic [3:0] REG_HIST_DATA     = 4'd7;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;
    localparam int CTRL_CLEAR_BIT     = 2;
    localparam int STATUS_DRIFT_BIT   = 0;
    localparam int STATUS_WRAPPED_BIT = 1;

endpackage

// File: rtl/drift_accuracy_monitor_sdp_ram.sv
// Simple dual-port RAM with a registered read port; reading an address in the
// same cycle it is written returns the previous contents.
module sdp_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    // Write port, owned by the window accumulator.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, owned by the slave interface.
    always_ff @(posedge clk) begin
        q <= mem[raddr];
    end

endmodule

// File: rtl/drift_accuracy_monitor.sv
// Per-window accuracy tracker with circular history and sticky drift detection,
// exposed to the CPU through a small Avalon-MM register slave.
module drift_accuracy_monitor
    import drift_mon_pkg::*;
#(
    parameter int LABEL_WIDTH   = 8,
    parameter int WINDOW_SIZE   = 100,
    parameter int HIST_AW       = 10,
    parameter int COUNT_WIDTH   = 32,
    parameter int WIN_CW        = 16,
    parameter int DRIFT_WINDOWS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    input  logic [LABEL_WIDTH-1:0] res_pred,
    input  logic [LABEL_WIDTH-1:0] res_label,
    input  logic [3:0]             slave_address,
    input  logic                   slave_read,
    output logic [31:0]            slave_readdata,
    input  logic                   slave_write,
    input  logic [31:0]            slave_writedata,
    output logic                   slave_waitrequest,
    output logic                   drift_irq,
    output logic                   window_done
);

    localparam int BR_W = $clog2(DRIFT_WINDOWS + 1);
    localparam logic [BR_W-1:0]   BR_MAX   = BR_W'(DRIFT_WINDOWS);
    localparam logic [WIN_CW-1:0] WIN_LAST = WIN_CW'(WINDOW_SIZE - 1);

    // Control registers
    logic                   ctrl_en_q, ctrl_en_d;
    logic                   irq_en_q, irq_en_d;
    logic [WIN_CW-1:0]      threshold_q, threshold_d;
    logic [HIST_AW-1:0]     hist_addr_q, hist_addr_d;

    // Accumulator state
    logic [COUNT_WIDTH-1:0] total_seen_q, total_seen_d;
    logic [COUNT_WIDTH-1:0] total_correct_q, total_correct_d;
    logic [COUNT_WIDTH-1:0] window_idx_q, window_idx_d;
    logic [WIN_CW-1:0]      win_cnt_q, win_cnt_d;
    logic [WIN_CW-1:0]      win_correct_q, win_correct_d;
    logic [HIST_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic                   wrapped_q, wrapped_d;
    logic [BR_W-1:0]        bad_run_q, bad_run_d;
    logic                   drift_set_q, drift_set_d;
    logic                   drift_q, drift_d;
    logic                   window_done_q, window_done_d;

    // Slave interface state
    slave_state_t           state_q;
    logic [31:0]            readdata_q;
    logic [31:0]            reg_rdata;
    logic [WIN_CW-1:0]      ram_q;

    // Decoded events
    logic                   wr_fire;
    logic                   clear_now;
    logic                   w1c_drift;
    logic                   counted;
    logic                   hit;
    logic                   win_last;
    logic                   win_close;
    logic [WIN_CW-1:0]      closed_count;
    logic [BR_W-1:0]        bad_run_next;
    logic                   unused_wdata;

    assign unused_wdata = ^slave_writedata;

    // Decode bus writes and the per-sample events that drive the accumulator.
    always_comb begin
        wr_fire      = (state_q == S_IDLE) && slave_write;
        clear_now    = wr_fire && (slave_address == REG_CTRL)
                       && slave_writedata[CTRL_CLEAR_BIT];
        w1c_drift    = wr_fire && (slave_address == REG_STATUS)
                       && slave_writedata[STATUS_DRIFT_BIT];
        counted      = res_valid && ctrl_en_q && !clear_now;
        hit          = (res_pred == res_label);
        win_last     = (win_cnt_q == WIN_LAST);
        win_close    = counted && win_last;
        closed_count = win_correct_q + WIN_CW'(hit);
        if (closed_count < threshold_q) begin
            bad_run_next = (bad_run_q == BR_MAX) ? bad_run_q : bad_run_q + BR_W'(1);
        end else begin
            bad_run_next = '0;
        end
    end

    // CPU-writable control fields; writes land in the first cycle of a transfer.
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;
        hist_addr_d = hist_addr_q;
        if (wr_fire) begin
            case (slave_address)
                REG_CTRL: begin
                    ctrl_en_d = slave_writedata[CTRL_ENABLE_BIT];
                    irq_en_d  = slave_writedata[CTRL_IRQ_EN_BIT];
                end
                REG_THRESHOLD: threshold_d = slave_writedata[WIN_CW-1:0];
                REG_HIST_ADDR: hist_addr_d = slave_writedata[HIST_AW-1:0];
                default: ;
            endcase
        end
    end

    // Sample accumulation, window close bookkeeping and the drift run counter.
    always_comb begin
        total_seen_d    = total_seen_q;
        total_correct_d = total_correct_q;
        window_idx_d    = window_idx_q;
        win_cnt_d       = win_cnt_q;
        win_correct_d   = win_correct_q;
        wr_ptr_d        = wr_ptr_q;
        wrapped_d       = wrapped_q;
        bad_run_d       = bad_run_q;
        window_done_d   = win_close;
        drift_set_d     = win_close && (bad_run_next == BR_MAX);
        if (clear_now) begin
            total_seen_d    = '0;
            total_correct_d = '0;
            window_idx_d    = '0;
            win_cnt_d       = '0;
            win_correct_d   = '0;
            wr_ptr_d        = '0;
            wrapped_d       = 1'b0;
            bad_run_d       = '0;
        end else if (counted) begin
            if (total_seen_q != '1) begin
                total_seen_d = total_seen_q + COUNT_WIDTH'(1);
            end
            if (hit && (total_correct_q != '1)) begin
                total_correct_d = total_correct_q + COUNT_WIDTH'(1);
            end
            if (win_last) begin
                win_cnt_d     = '0;
                win_correct_d = '0;
                wr_ptr_d      = wr_ptr_q + HIST_AW'(1);
                if (wr_ptr_q == '1) begin
                    wrapped_d = 1'b1;
                end
                window_idx_d  = window_idx_q + COUNT_WIDTH'(1);
                bad_run_d     = bad_run_next;
            end else begin
                win_cnt_d     = win_cnt_q + WIN_CW'(1);
                win_correct_d = closed_count;
            end
        end
    end

    // Sticky drift flag: clear dominates, a pending set beats a same-cycle W1C.
    always_comb begin
        drift_d = drift_q;
        if (clear_now) begin
            drift_d = 1'b0;
        end else if (drift_set_q) begin
            drift_d = 1'b1;
        end else if (w1c_drift) begin
            drift_d = 1'b0;
        end
    end

    // Register-space read multiplexer, sampled by the slave FSM.
    always_comb begin
        reg_rdata = '0;
        case (slave_address)
            REG_CTRL: begin
                reg_rdata[CTRL_ENABLE_BIT] = ctrl_en_q;
                reg_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_STATUS: begin
                reg_rdata[STATUS_DRIFT_BIT]   = drift_q;
                reg_rdata[STATUS_WRAPPED_BIT] = wrapped_q;
            end
            REG_TOTAL_SEEN:    reg_rdata = 32'(total_seen_q);
            REG_TOTAL_CORRECT: reg_rdata = 32'(total_correct_q);
            REG_WINDOW_IDX:    reg_rdata = 32'(window_idx_q);
            REG_THRESHOLD:     reg_rdata = 32'(threshold_q);
            REG_HIST_ADDR:     reg_rdata = 32'(hist_addr_q);
            default:           reg_rdata = '0;
        endcase
    end

    // State flops for control, accumulator and drift logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q       <= 1'b0;
            irq_en_q        <= 1'b0;
            threshold_q     <= '0;
            hist_addr_q     <= '0;
            total_seen_q    <= '0;
            total_correct_q <= '0;
            window_idx_q    <= '0;
            win_cnt_q       <= '0;
            win_correct_q   <= '0;
            wr_ptr_q        <= '0;
            wrapped_q       <= 1'b0;
            bad_run_q       <= '0;
            drift_set_q     <= 1'b0;
            drift_q         <= 1'b0;
            window_done_q   <= 1'b0;
        end else begin
            ctrl_en_q       <= ctrl_en_d;
            irq_en_q        <= irq_en_d;
            threshold_q     <= threshold_d;
            hist_addr_q     <= hist_addr_d;
            total_seen_q    <= total_seen_d;
            total_correct_q <= total_correct_d;
            window_idx_q    <= window_idx_d;
            win_cnt_q       <= win_cnt_d;
            win_correct_q   <= win_correct_d;
            wr_ptr_q        <= wr_ptr_d;
            wrapped_q       <= wrapped_d;
            bad_run_q       <= bad_run_d;
            drift_set_q     <= drift_set_d;
            drift_q         <= drift_d;
            window_done_q   <= window_done_d;
        end
    end

    // Slave FSM: register reads latch immediately, history reads wait on the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            readdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (slave_write) begin
                        state_q <= S_ACK;
                    end else if (slave_read) begin
                        if (slave_address == REG_HIST_DATA) begin
                            state_q <= S_RAM;
                        end else begin
                            readdata_q <= reg_rdata;
                            state_q    <= S_ACK;
                        end
                    end
                end
                S_RAM:   state_q <= S_RAM2;
                S_RAM2: begin
                    readdata_q <= 32'(ram_q);
                    state_q    <= S_ACK;
                end
                S_ACK:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Waitrequest stalls the master until the FSM reaches its acknowledge cycle.
    always_comb begin
        case (state_q)
            S_IDLE:  slave_waitrequest = rst_n && (slave_read || slave_write);
            S_RAM:   slave_waitrequest = 1'b1;
            S_RAM2:  slave_waitrequest = 1'b1;
            default: slave_waitrequest = 1'b0;
        endcase
    end

    assign slave_readdata = readdata_q;
    assign window_done    = window_done_q;
    assign drift_irq      = drift_q && irq_en_q;

    sdp_ram #(
        .AW (HIST_AW),
        .DW (WIN_CW)
    ) u_hist (
        .clk   (clk),
        .we    (win_close),
        .waddr (wr_ptr_q),
        .wdata (closed_count),
        .raddr (hist_addr_q),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_drift_accuracy_monitor.sv
// Directed bench for drift_accuracy_monitor; read responses go through a scoreboard
// queue that a separate monitor process drains as transfers complete.
module tb_drift_accuracy_monitor;
    import drift_mon_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        res_valid;
    logic [7:0]  res_pred;
    logic [7:0]  res_label;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic        drift_irq;
    logic        window_done;

    int checks = 0;
    int errors = 0;
    int wd_count = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    drift_accuracy_monitor #(
        .HIST_AW (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .res_valid         (res_valid),
        .res_pred          (res_pred),
        .res_label         (res_label),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_waitrequest (slave_waitrequest),
        .drift_irq         (drift_irq),
        .window_done       (window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read transfer completes.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && slave_read && !slave_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read: got %0d expected none", slave_readdata);
                end else begin
                    checkOutput(name_q.pop_front(), slave_readdata, exp_q.pop_front());
                end
            end
            if (window_done) wd_count++;
        end
    end

    // Watchdog so a stuck transfer still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // All tasks start and end 1ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busTransfer(input logic is_write, input logic [3:0] addr,
                               input logic [31:0] data, input string name, input int lat);
        int cycles = 0;
        bit done = 0;
        slave_address   = addr;
        slave_writedata = data;
        slave_read      = !is_write;
        slave_write     = is_write;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (!slave_waitrequest) done = 1;
            @(posedge clk);
            #1;
        end
        slave_read  = 1'b0;
        slave_write = 1'b0;
        checkOutput({name, "_lat"}, cycles, lat);
    endtask

    task automatic busRead(input logic [3:0] addr, input logic [31:0] expected,
                           input string name);
        exp_q.push_back(expected);
        name_q.push_back(name);
        busTransfer(1'b0, addr, 32'd0, name, (addr == REG_HIST_DATA) ? 4 : 2);
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
        busTransfer(1'b1, addr, data, "write", 2);
    endtask

    task automatic readHist(input int idx, input logic [31:0] expected, input string name);
        busWrite(REG_HIST_ADDR, idx);
        busRead(REG_HIST_DATA, expected, name);
    endtask

    // Drives n back-to-back samples, the first n_correct of which are hits.
    task automatic applyStimulus(input int n, input int n_correct);
        for (int i = 0; i < n; i++) begin
            res_valid = 1'b1;
            res_pred  = 8'(i);
            res_label = (i < n_correct) ? 8'(i) : 8'(i + 1);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        res_valid = 1'b0;
        res_pred = '0;
        res_label = '0;
        slave_address = '0;
        slave_read = 1'b0;
        slave_write = 1'b0;
        slave_writedata = '0;
        tick(3);
        checkOutput("rst_waitreq", slave_waitrequest, 0);
        checkOutput("rst_rdata", slave_readdata, 0);
        checkOutput("rst_irq", drift_irq, 0);
        checkOutput("rst_wdone", window_done, 0);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] reset register values");
        for (int a = 0; a < 6; a++) busRead(4'(a), 32'd0, $sformatf("rst_reg%0d", a));

        $display("[TB] single window, 95 of 100 correct");
        busWrite(REG_THRESHOLD, 90);
        busWrite(REG_CTRL, 1);
        applyStimulus(100, 95);
        busRead(REG_TOTAL_SEEN, 100, "w1_seen");
        busRead(REG_TOTAL_CORRECT, 95, "w1_correct");
        busRead(REG_WINDOW_IDX, 1, "w1_idx");
        readHist(0, 95, "w1_hist0");
        busRead(REG_STATUS, 0, "w1_status");
        checkOutput("w1_wdone_cnt", wd_count, 1);

        $display("[TB] drift run 80,80,95,80,80,80");
        busWrite(REG_CTRL, 7);
        busRead(REG_CTRL, 3, "ctrl_rb");
        applyStimulus(100, 80);
        applyStimulus(100, 80);
        tick(2);
        checkOutput("d2_irq", drift_irq, 0);
        applyStimulus(100, 95);
        applyStimulus(100, 80);
        applyStimulus(100, 80);
        tick(2);
        checkOutput("d5_irq", drift_irq, 0);
        busRead(REG_STATUS, 2, "d5_status");
        applyStimulus(100, 80);
        tick(2);
        busRead(REG_STATUS, 3, "d6_status");
        checkOutput("d6_irq", drift_irq, 1);
        checkOutput("d6_wdone_cnt", wd_count, 7);
        busWrite(REG_STATUS, 1);
        busRead(REG_STATUS, 2, "w1c_status");
        checkOutput("w1c_irq", drift_irq, 0);

        $display("[TB] window close colliding with drift W1C");
        applyStimulus(100, 80);
        busWrite(REG_STATUS, 1);
        tick(2);
        busRead(REG_STATUS, 3, "coll_status");
        checkOutput("coll_irq", drift_irq, 1);
        busWrite(REG_STATUS, 1);

        $display("[TB] history wrap with depth 4");
        busWrite(REG_THRESHOLD, 0);
        busWrite(REG_CTRL, 7);
        applyStimulus(100, 10);
        applyStimulus(100, 20);
        applyStimulus(100, 30);
        applyStimulus(100, 40);
        applyStimulus(100, 50);
        tick(2);
        busRead(REG_WINDOW_IDX, 5, "wr_idx");
        busRead(REG_TOTAL_SEEN, 500, "wr_seen");
        busRead(REG_TOTAL_CORRECT, 150, "wr_correct");
        busRead(REG_STATUS, 2, "wr_status");
        readHist(0, 50, "wr_hist0");
        readHist(1, 20, "wr_hist1");
        readHist(2, 30, "wr_hist2");
        readHist(3, 40, "wr_hist3");
        checkOutput("wr_wdone_cnt", wd_count, 13);

        $display("[TB] clear colliding with a sample mid-window");
        busWrite(REG_CTRL, 5);
        applyStimulus(50, 50);
        fork
            busWrite(REG_CTRL, 5);
            begin
                res_valid = 1'b1;
                res_pred  = 8'd3;
                res_label = 8'd3;
                @(posedge clk);
                #1;
                res_valid = 1'b0;
            end
        join
        busRead(REG_TOTAL_SEEN, 0, "clr_seen");
        busRead(REG_TOTAL_CORRECT, 0, "clr_correct");
        busRead(REG_WINDOW_IDX, 0, "clr_idx");
        busRead(REG_STATUS, 0, "clr_status");
        applyStimulus(99, 99);
        busRead(REG_WINDOW_IDX, 0, "clr99_idx");
        busRead(REG_TOTAL_SEEN, 99, "clr99_seen");
        checkOutput("clr99_wdone_cnt", wd_count, 13);
        applyStimulus(1, 1);
        busRead(REG_WINDOW_IDX, 1, "clr100_idx");
        readHist(0, 100, "clr_hist0");
        checkOutput("clr100_wdone_cnt", wd_count, 14);

        $display("[TB] samples ignored while disabled");
        busWrite(REG_CTRL, 0);
        applyStimulus(10, 10);
        busRead(REG_TOTAL_SEEN, 100, "dis_seen");
        busRead(REG_TOTAL_CORRECT, 100, "dis_correct");
        busRead(REG_WINDOW_IDX, 1, "dis_idx");
        busRead(REG_CTRL, 0, "dis_ctrl");

        $display("[TB] unmapped address");
        busWrite(4'd9, 32'hFFFF_FFFF);
        busRead(4'd9, 0, "unmapped_rd");
        busRead(REG_THRESHOLD, 0, "unmapped_thr");

        tick(3);
        checkOutput("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
